// File: rtl/adex_spike_monitor.sv
// adex_spike_monitor: firing-rate and inter-spike-interval statistics for the AdEx core,
// read out as a 10-nibble valid/ready record. Define ADEX_MON_BURST_EN to build burst detection.
module adex_spike_monitor #(
    parameter int unsigned WIN_STEPS  = 1000,
    parameter int unsigned BURST_ISI  = 16,
    parameter logic [3:0]  HEADER_NIB = 4'hA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        step_strobe,
    input  logic        spike_in,
    input  logic        clear,
    input  logic        rd_req,
    input  logic        rd_ready,
    output logic        rd_valid,
    output logic [3:0]  rd_nibble,
    output logic        rd_last,
    output logic        busy,
    output logic        win_done,
    output logic [7:0]  rate_cnt,
    output logic [11:0] isi_last
);

    localparam logic [15:0] WIN_LAST = 16'(WIN_STEPS - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_SNAP,
        R_SEND
    } rd_state_t;

    logic        r_spike_d;
    logic [7:0]  r_live_cnt;
    logic [15:0] r_win_cnt;
    logic [11:0] r_isi_cnt;
    logic [11:0] r_isi_min;
    logic        r_have_prev;
    logic        r_isat;
    logic        r_ovf;
    logic        r_win_done;
    logic [7:0]  r_rate_cnt;
    logic [11:0] r_isi_last;

    logic        w_rise;
    logic        w_step;
    logic        w_win_close;
    logic [12:0] w_isi_sum;
    logic [11:0] w_isi_capt;
    logic [8:0]  w_rate_sum;
    logic [7:0]  w_rate_next;
    logic        w_burst;

    // Statistics only see qualified events; the edge detector itself runs even while disabled.
    assign w_rise      = spike_in & ~r_spike_d & enable;
    assign w_step      = step_strobe & enable;
    assign w_win_close = w_step && (r_win_cnt == WIN_LAST);

    assign w_isi_sum   = {1'b0, r_isi_cnt} + {12'd0, w_step};
    assign w_isi_capt  = w_isi_sum[12] ? 12'hFFF : w_isi_sum[11:0];
    assign w_rate_sum  = {1'b0, r_live_cnt} + {8'd0, w_rise};
    assign w_rate_next = w_rate_sum[8] ? 8'hFF : w_rate_sum[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spike_d <= 1'b0;
        end else begin
            r_spike_d <= spike_in;
        end
    end

    // NOTE: every state update is non-blocking, so all branches below read start-of-cycle values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_live_cnt  <= '0;
            r_win_cnt   <= '0;
            r_isi_cnt   <= '0;
            r_isi_min   <= 12'hFFF;
            r_have_prev <= 1'b0;
            r_isat      <= 1'b0;
            r_ovf       <= 1'b0;
            r_win_done  <= 1'b0;
            r_rate_cnt  <= '0;
            r_isi_last  <= '0;
        end else begin
            r_win_done <= w_win_close;
            if (w_step) begin
                if (w_win_close) begin
                    r_win_cnt <= '0;
                end else begin
                    r_win_cnt <= r_win_cnt + 16'd1;
                end
                if (r_isi_cnt == 12'hFFF) begin
                    r_isat <= 1'b1;
                end else begin
                    r_isi_cnt <= r_isi_cnt + 12'd1;
                end
            end
            if (w_rise) begin
                if (r_live_cnt == 8'hFF) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_live_cnt <= r_live_cnt + 8'd1;
                end
                if (r_have_prev) begin
                    r_isi_last <= w_isi_capt;
                    if (w_isi_capt < r_isi_min) begin
                        r_isi_min <= w_isi_capt;
                    end
                end
                r_have_prev <= 1'b1;
                r_isi_cnt   <= '0;
            end
            // A rise on the closing strobe is folded into the window being closed.
            if (w_win_close) begin
                r_live_cnt <= '0;
                r_rate_cnt <= w_rate_next;
            end
        end
    end

`ifdef ADEX_MON_BURST_EN
    logic [1:0] r_burst_run;
    logic       r_burst;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_burst_run <= '0;
            r_burst     <= 1'b0;
        end else if (w_rise && r_have_prev) begin
            if (32'(w_isi_capt) < BURST_ISI) begin
                if (r_burst_run != 2'd3) begin
                    r_burst_run <= r_burst_run + 2'd1;
                end
                // Run reaching 2 means three closely spaced spikes.
                if (r_burst_run != 2'd0) begin
                    r_burst <= 1'b1;
                end
            end else begin
                r_burst_run <= '0;
            end
        end
    end

    assign w_burst = r_burst;
`else
    logic w_unused_burst_isi;

    assign w_unused_burst_isi = (BURST_ISI == 0);
    assign w_burst            = 1'b0;
`endif

    rd_state_t   r_state;
    logic [39:0] r_snap;
    logic [3:0]  r_nib_idx;
    logic        r_rd_valid;
    logic        r_rd_last;
    logic        r_busy;

    logic [39:0] w_snap;
    logic        w_accept;

    assign w_snap   = {HEADER_NIB, r_rate_cnt, r_isi_last, r_isi_min,
                       w_burst, r_have_prev, r_isat, r_ovf};
    assign w_accept = r_rd_valid & rd_ready;

    // The record is shifted out MSN-first; after the tenth nibble only zeros remain.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_state    <= R_IDLE;
            r_snap     <= '0;
            r_nib_idx  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (rd_req) begin
                        r_state <= R_SNAP;
                        r_busy  <= 1'b1;
                    end
                end
                R_SNAP: begin
                    r_snap     <= w_snap;
                    r_nib_idx  <= '0;
                    r_rd_valid <= 1'b1;
                    r_state    <= R_SEND;
                end
                R_SEND: begin
                    if (w_accept) begin
                        r_snap <= {r_snap[35:0], 4'h0};
                        if (r_nib_idx == 4'd9) begin
                            r_state    <= R_IDLE;
                            r_rd_valid <= 1'b0;
                            r_rd_last  <= 1'b0;
                            r_busy     <= 1'b0;
                        end else begin
                            r_nib_idx <= r_nib_idx + 4'd1;
                            r_rd_last <= (r_nib_idx == 4'd8);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_nibble = r_snap[39:36];
    assign rd_last   = r_rd_last;
    assign busy      = r_busy;
    assign win_done  = r_win_done;
    assign rate_cnt  = r_rate_cnt;
    assign isi_last  = r_isi_last;

endmodule

// File: tb/tb_adex_spike_monitor.sv
// Directed bench for adex_spike_monitor with default parameters (WIN_STEPS=1000, BURST_ISI=16).
// The expected burst flag follows whether ADEX_MON_BURST_EN is defined for the build.
`timescale 1ns/1ps
module tb_adex_spike_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        step_strobe;
    logic        spike_in;
    logic        clear;
    logic        rd_req;
    logic        rd_ready;
    logic        rd_valid;
    logic [3:0]  rd_nibble;
    logic        rd_last;
    logic        busy;
    logic        win_done;
    logic [7:0]  rate_cnt;
    logic [11:0] isi_last;

    int n_tests = 0;
    int n_fail  = 0;
    int wd_cnt;
    int wd_at;

`ifdef ADEX_MON_BURST_EN
    localparam logic [3:0] BURST_FLAG = 4'h8;
`else
    localparam logic [3:0] BURST_FLAG = 4'h0;
`endif

    always #5 clk = ~clk;

    adex_spike_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .step_strobe(step_strobe),
        .spike_in   (spike_in),
        .clear      (clear),
        .rd_req     (rd_req),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_nibble  (rd_nibble),
        .rd_last    (rd_last),
        .busy       (busy),
        .win_done   (win_done),
        .rate_cnt   (rate_cnt),
        .isi_last   (isi_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given strobe/spike levels; both return to 0 afterwards.
    task automatic cyc(input logic strobe, input logic spike);
        step_strobe = strobe;
        spike_in    = spike;
        tick();
        step_strobe = 1'b0;
        spike_in    = 1'b0;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
    endtask

    task automatic spike(input int hold, input logic strobe_low);
        for (int i = 0; i < hold; i++) cyc(1'b0, 1'b1);
        cyc(strobe_low, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Full record readout; toggle alternates rd_ready starting low, hold_req leaves rd_req high.
    task automatic readout(input string tag, input logic [39:0] exp, input bit toggle, input bit hold_req);
        logic [39:0] rec;
        logic [3:0]  held_nib;
        bit          held;
        int          n;
        int          lat;
        rec      = '0;
        held_nib = '0;
        held     = 1'b0;
        n        = 0;
        rd_req   = 1'b1;
        tick();
        lat = 1;
        if (!hold_req) rd_req = 1'b0;
        while (!rd_valid && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, 2);
        for (int c = 0; c < 60 && n < 10; c++) begin
            if (held) check({tag, ".hold"}, rd_nibble, held_nib);
            rd_ready = toggle ? 1'(c % 2) : 1'b1;
            held     = 1'b0;
            if (rd_valid) begin
                check({tag, ".last"}, rd_last, (n == 9));
                if (rd_ready) begin
                    rec = {rec[35:0], rd_nibble};
                    n++;
                end else begin
                    held     = 1'b1;
                    held_nib = rd_nibble;
                end
            end
            tick();
        end
        rd_ready = 1'b0;
        check({tag, ".count"}, n, 10);
        check({tag, ".record"}, rec, exp);
        check({tag, ".idle_valid"}, rd_valid, 1'b0);
        check({tag, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        step_strobe = 1'b0;
        spike_in    = 1'b0;
        clear       = 1'b0;
        rd_req      = 1'b0;
        rd_ready    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state and empty record; rd_req held high re-triggers after an idle cycle.
        repeat (20) tick();
        check("t1.outputs", {rd_valid, rd_nibble, rd_last, busy, win_done, rate_cnt, isi_last}, '0);
        readout("t1.rd_a", 40'hA00000FFF0, 1'b0, 1'b1);
        readout("t1.rd_b", 40'hA00000FFF0, 1'b0, 1'b0);

        // One spike every 50 strobes across one full window; readout with toggling ready.
        do_clear();
        wd_cnt = 0;
        wd_at  = -1;
        for (int s = 1; s <= 1000; s++) begin
            cyc(1'b0, (s % 50) == 0);
            cyc(1'b1, 1'b0);
            if (win_done) begin
                wd_cnt++;
                wd_at = s;
            end
        end
        check("t2.win_done_count", wd_cnt, 1);
        check("t2.win_done_at", wd_at, 1000);
        check("t2.rate", rate_cnt, 20);
        check("t2.isi_last", isi_last, 50);
        cyc(1'b0, 1'b0);
        check("t2.win_done_pulse", win_done, 1'b0);
        readout("t4.toggle", 40'hA140320324, 1'b1, 1'b0);

        // Spikes held 7 cycles are counted once each.
        do_clear();
        for (int i = 0; i < 5; i++) spike(7, 1'b1);
        strobes(995);
        check("t3.rate_once", rate_cnt, 5);
        check("t3.isi_once", isi_last, 1);

        // 300 spikes in one window: rate saturates, ovf flag set.
        do_clear();
        for (int i = 0; i < 300; i++) spike(7, 1'b1);
        strobes(700);
        check("t3.rate_sat", rate_cnt, 255);
        readout("t3.ovf", 40'hAFF0010015, 1'b0, 1'b0);

        // Rise on the window-closing strobe with isi_cnt at 9.
        do_clear();
        strobes(990);
        spike(1, 1'b0);
        strobes(9);
        cyc(1'b1, 1'b1);
        check("t5.win_done", win_done, 1'b1);
        check("t5.rate_edge", rate_cnt, 2);
        check("t5.isi_edge", isi_last, 10);
        cyc(1'b0, 1'b0);

        // Clear while the fourth nibble is presented.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        check("t5.first_nib", {rd_valid, rd_nibble}, {1'b1, 4'hA});
        rd_ready = 1'b1;
        repeat (2) tick();
        check("t5.third_nib", rd_nibble, 4'h2);
        tick();
        clear = 1'b1;
        tick();
        clear    = 1'b0;
        rd_ready = 1'b0;
        check("t5.clr_valid", rd_valid, 1'b0);
        check("t5.clr_busy", busy, 1'b0);
        check("t5.clr_stats", {rate_cnt, isi_last}, '0);
        readout("t5.after_clear", 40'hA00000FFF0, 1'b0, 1'b0);

        // Disabled statistics ignore spikes and strobes.
        enable = 1'b0;
        spike(1, 1'b1);
        spike(1, 1'b1);
        strobes(5);
        enable = 1'b1;
        readout("t7.frozen", 40'hA00000FFF0, 1'b0, 1'b0);

        // ISI counter saturation sets isat.
        do_clear();
        strobes(4096);
        readout("t8.isat", 40'hA00000FFF2, 1'b0, 1'b0);

        // ISIs 10, 10, 40: burst flag after the second ISI and sticky afterwards.
        do_clear();
        spike(1, 1'b0);
        strobes(10);
        spike(1, 1'b0);
        readout("t6.one_isi", {4'hA, 8'h00, 12'h00A, 12'h00A, 4'h4}, 1'b0, 1'b0);
        strobes(10);
        spike(1, 1'b0);
        readout("t6.two_isi", {4'hA, 8'h00, 12'h00A, 12'h00A, BURST_FLAG | 4'h4}, 1'b0, 1'b0);
        strobes(40);
        spike(1, 1'b0);
        readout("t6.long_isi", {4'hA, 8'h00, 12'h028, 12'h00A, BURST_FLAG | 4'h4}, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
